// File: rtl/mapper_pkg.sv
// Shared types and defaults for the pixel-to-complex-plane mapper.
package mapper_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int W_DEF     = 32;
  localparam int FRAC_DEF  = 28;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef logic signed [W_DEF-1:0] fixed_t;

  // Bit position of a lane within a packed multi-lane word.
  function automatic int lane_bit(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/coord_accum.sv
// Latches the view window at frame start and steps the row-base / imaginary
// accumulators; lane coordinates are the row base plus fixed per-lane offsets.
module coord_accum
  import mapper_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LANES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic                 i_next_beat,
  input  logic                 i_next_line,
  input  logic signed [W-1:0]  i_zf,
  input  logic signed [W-1:0]  i_re_lower,
  input  logic signed [W-1:0]  i_im_upper,
  output logic [LANES*W-1:0]   o_re,
  output logic signed [W-1:0]  o_im
);

  logic signed [W-1:0] w_off [LANES];
  logic signed [W-1:0] w_step;
  logic signed [W-1:0] r_off [LANES];
  logic signed [W-1:0] r_zf;
  logic signed [W-1:0] r_re0;
  logic signed [W-1:0] r_step;
  logic signed [W-1:0] r_rb;
  logic signed [W-1:0] r_im;

  // Constant-factor scaling happens once per frame; per-pixel work is adds only.
  for (genvar k = 0; k < LANES; k++) begin : g_off
    localparam int KI = k;
    assign w_off[k] = W'(i_zf * KI);
  end
  assign w_step = W'(i_zf * LANES);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_zf   <= '0;
      r_re0  <= '0;
      r_step <= '0;
      r_rb   <= '0;
      r_im   <= '0;
      for (int k = 0; k < LANES; k++) r_off[k] <= '0;
    end else if (i_load) begin
      r_zf   <= i_zf;
      r_re0  <= i_re_lower;
      r_step <= w_step;
      r_rb   <= i_re_lower;
      r_im   <= i_im_upper;
      for (int k = 0; k < LANES; k++) r_off[k] <= w_off[k];
    end else if (i_next_line) begin
      r_rb <= r_re0;
      r_im <= r_im - r_zf;
    end else if (i_next_beat) begin
      r_rb <= r_rb + r_step;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign o_re[lane_bit(k, W) +: W] = r_rb + r_off[k];
  end
  assign o_im = r_im;

endmodule

// File: rtl/pixel_coord_stream.sv
// Raster walker streaming LANES complex-plane pixel coordinates per beat
// over valid/ready; the view window is frozen for the whole frame.
module pixel_coord_stream
  import mapper_pkg::*;
#(
  parameter  int W     = W_DEF,
  parameter  int FRAC  = FRAC_DEF,
  parameter  int H_RES = H_RES_DEF,
  parameter  int V_RES = V_RES_DEF,
  parameter  int LANES = 1,
  localparam int XW    = $clog2(H_RES),
  localparam int YW    = $clog2(V_RES)
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic                stop,
  input  logic                cont,
  input  logic signed [W-1:0] zoom_factor,
  input  logic signed [W-1:0] re_lower,
  input  logic signed [W-1:0] im_upper,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [LANES*W-1:0]  m_re,
  output logic [W-1:0]        m_im,
  output logic [XW-1:0]       m_x,
  output logic [YW-1:0]       m_y,
  output logic                m_sof,
  output logic                m_eol,
  output logic                busy,
  output logic                frame_done
);

  if (H_RES % LANES != 0) begin : g_bad_hres
    $error("H_RES must be a multiple of LANES");
  end
  if (FRAC >= W) begin : g_bad_frac
    $error("FRAC must be smaller than W");
  end

  state_t        r_state;
  state_t        w_state_nxt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_done;
  logic          w_hs;
  logic          w_eol;
  logic          w_last;
  logic          w_load;
  logic          w_next_beat;
  logic          w_next_line;
  logic [W-1:0]  w_im;

  assign w_eol  = (r_x == XW'(H_RES - LANES));
  assign w_hs   = (r_state == RUN) && m_ready;
  assign w_last = w_hs && w_eol && (r_y == YW'(V_RES - 1));

  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // stop outranks the final handshake; cont reloads the window from live inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_next_beat = 1'b0;
    w_next_line = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          if (cont) w_load = 1'b1;
          else      w_state_nxt = IDLE;
        end else if (w_hs) begin
          if (w_eol) w_next_line = 1'b1;
          else       w_next_beat = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last && !stop;
      if (w_load) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_next_line) begin
        r_x <= '0;
        r_y <= r_y + YW'(1);
      end else if (w_next_beat) begin
        r_x <= r_x + XW'(LANES);
      end
    end
  end

  coord_accum #(
    .W     (W),
    .LANES (LANES)
  ) u_accum (
    .i_clk       (aclk),
    .i_rst       (areset),
    .i_load      (w_load),
    .i_next_beat (w_next_beat),
    .i_next_line (w_next_line),
    .i_zf        (zoom_factor),
    .i_re_lower  (re_lower),
    .i_im_upper  (im_upper),
    .o_re        (m_re),
    .o_im        (w_im)
  );

  assign m_im       = w_im;
  assign m_valid    = (r_state == RUN);
  assign m_x        = r_x;
  assign m_y        = r_y;
  assign m_sof      = m_valid && (r_x == '0) && (r_y == '0);
  assign m_eol      = m_valid && w_eol;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_done;

endmodule

// File: tb/tb_pixel_coord_stream.sv
// Directed bench for pixel_coord_stream: 8x4 raster, two lanes per beat.
module tb_pixel_coord_stream;

  localparam int W      = 32;
  localparam int FRAC   = 28;
  localparam int H_RES  = 8;
  localparam int V_RES  = 4;
  localparam int LANES  = 2;
  localparam int XW     = $clog2(H_RES);
  localparam int YW     = $clog2(V_RES);
  localparam int BPL    = H_RES / LANES;
  localparam int NBEATS = BPL * V_RES;

  localparam logic [31:0] ZF  = 32'h0100_0000;
  localparam logic [31:0] ZF2 = 32'h0080_0000;
  localparam logic [31:0] RE0 = 32'hE000_0000;
  localparam logic [31:0] IM0 = 32'h1000_0000;

  logic                 aclk = 1'b0;
  logic                 areset, start, stop, cont, m_ready;
  logic [W-1:0]         zoom_factor, re_lower, im_upper;
  logic                 m_valid, m_sof, m_eol, busy, frame_done;
  logic [LANES*W-1:0]   m_re;
  logic [W-1:0]         m_im;
  logic [XW-1:0]        m_x;
  logic [YW-1:0]        m_y;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ready;
    logic [31:0] re0;
    logic [31:0] re1;
    logic [31:0] im;
    int          x;
    int          y;
    logic        sof;
    logic        eol;
  } vec_t;

  vec_t tbl [NBEATS];

  pixel_coord_stream #(
    .W     (W),
    .FRAC  (FRAC),
    .H_RES (H_RES),
    .V_RES (V_RES),
    .LANES (LANES)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .start       (start),
    .stop        (stop),
    .cont        (cont),
    .zoom_factor (zoom_factor),
    .re_lower    (re_lower),
    .im_upper    (im_upper),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_re        (m_re),
    .m_im        (m_im),
    .m_x         (m_x),
    .m_y         (m_y),
    .m_sof       (m_sof),
    .m_eol       (m_eol),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] exp_re(input logic [31:0] base, input logic [31:0] zf,
                                         input int b, input int lane);
    int pix;
    pix = (b % BPL) * LANES + lane;
    return base + zf * 32'(pix);
  endfunction

  function automatic logic [31:0] exp_im(input logic [31:0] imu, input logic [31:0] zf, input int b);
    return imu - zf * 32'(b / BPL);
  endfunction

  task automatic check_beat(input string tag, input int b, input logic [31:0] base,
                            input logic [31:0] imu, input logic [31:0] zf);
    chk($sformatf("%s b%0d valid", tag, b), 32'(m_valid), 32'd1);
    chk($sformatf("%s b%0d x", tag, b), 32'(m_x), 32'((b % BPL) * LANES));
    chk($sformatf("%s b%0d y", tag, b), 32'(m_y), 32'(b / BPL));
    chk($sformatf("%s b%0d sof", tag, b), 32'(m_sof), 32'(b == 0));
    chk($sformatf("%s b%0d eol", tag, b), 32'(m_eol), 32'((b % BPL) == BPL - 1));
    for (int k = 0; k < LANES; k++)
      chk($sformatf("%s b%0d re%0d", tag, b, k), m_re[k*W +: W], exp_re(base, zf, b, k));
    chk($sformatf("%s b%0d im", tag, b), m_im, exp_im(imu, zf, b));
  endtask

  task automatic run_beats(input string tag, input int from, input int to, input logic [31:0] base,
                           input logic [31:0] imu, input logic [31:0] zf);
    for (int b = from; b <= to; b++) begin
      check_beat(tag, b, base, imu, zf);
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " valid"}, 32'(m_valid), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NBEATS; i++) begin
      tbl[i].ready = 1'b1;
      tbl[i].re0   = RE0 + ZF * 32'((i % BPL) * 2);
      tbl[i].re1   = RE0 + ZF * 32'((i % BPL) * 2 + 1);
      tbl[i].im    = IM0 - ZF * 32'(i / BPL);
      tbl[i].x     = (i % BPL) * 2;
      tbl[i].y     = i / BPL;
      tbl[i].sof   = (i == 0);
      tbl[i].eol   = ((i % BPL) == BPL - 1);
    end

    areset = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; m_ready = 1'b1;
    zoom_factor = ZF; re_lower = RE0; im_upper = IM0;
    tick(); tick();
    check_idle("reset");
    chk("reset re0", m_re[31:0], 32'd0);
    chk("reset re1", m_re[63:32], 32'd0);
    chk("reset im", m_im, 32'd0);
    chk("reset x", 32'(m_x), 32'd0);
    chk("reset y", 32'(m_y), 32'd0);
    areset = 1'b0;
    tick();
    check_idle("idle");

    // Basic frame from the vector table; a stray start at beat 2 must be ignored.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < NBEATS; i++) begin
      chk($sformatf("basic b%0d valid", i), 32'(m_valid), 32'd1);
      chk($sformatf("basic b%0d re0", i), m_re[31:0], tbl[i].re0);
      chk($sformatf("basic b%0d re1", i), m_re[63:32], tbl[i].re1);
      chk($sformatf("basic b%0d im", i), m_im, tbl[i].im);
      chk($sformatf("basic b%0d x", i), 32'(m_x), 32'(tbl[i].x));
      chk($sformatf("basic b%0d y", i), 32'(m_y), 32'(tbl[i].y));
      chk($sformatf("basic b%0d sof", i), 32'(m_sof), 32'(tbl[i].sof));
      chk($sformatf("basic b%0d eol", i), 32'(m_eol), 32'(tbl[i].eol));
      chk($sformatf("basic b%0d done", i), 32'(frame_done), 32'd0);
      if (i == 3) chk("basic beat3 re1 const", m_re[63:32], 32'hE700_0000);
      if (i == 4) chk("basic beat4 im const", m_im, 32'h0F00_0000);
      m_ready = tbl[i].ready;
      start = (i == 2);
      tick();
      start = 1'b0;
    end
    chk("basic frame_done", 32'(frame_done), 32'd1);
    chk("basic valid after", 32'(m_valid), 32'd0);
    chk("basic busy after", 32'(busy), 32'd0);
    tick();
    chk("basic done pulse width", 32'(frame_done), 32'd0);

    // Backpressure: three stalled cycles on beat 5.
    start = 1'b1; tick(); start = 1'b0;
    run_beats("bp", 0, 4, RE0, IM0, ZF);
    check_beat("bp", 5, RE0, IM0, ZF);
    m_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_beat($sformatf("bp stall%0d", s), 5, RE0, IM0, ZF);
    end
    m_ready = 1'b1;
    run_beats("bp", 5, NBEATS - 1, RE0, IM0, ZF);
    chk("bp frame_done", 32'(frame_done), 32'd1);

    // Window change mid-frame only affects the following frame.
    start = 1'b1; tick(); start = 1'b0;
    run_beats("cfg", 0, 5, RE0, IM0, ZF);
    re_lower = 32'd0;
    run_beats("cfg", 6, NBEATS - 1, RE0, IM0, ZF);
    chk("cfg frame_done", 32'(frame_done), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    run_beats("cfg next", 0, NBEATS - 1, 32'd0, IM0, ZF);
    chk("cfg next frame_done", 32'(frame_done), 32'd1);

    // Signed wrap across the top of the range, then abort with stop.
    re_lower = 32'h7F00_0000;
    start = 1'b1; tick(); start = 1'b0;
    chk("wrap re0", m_re[31:0], 32'h7F00_0000);
    chk("wrap re1", m_re[63:32], 32'h8000_0000);
    stop = 1'b1; tick(); stop = 1'b0;
    check_idle("wrap stop");

    // Continuous mode: new zoom picked up at the frame boundary, no bubble.
    re_lower = RE0;
    start = 1'b1; tick(); start = 1'b0;
    run_beats("cont", 0, NBEATS - 2, RE0, IM0, ZF);
    check_beat("cont", NBEATS - 1, RE0, IM0, ZF);
    cont = 1'b1; zoom_factor = ZF2;
    tick();
    cont = 1'b0;
    chk("cont frame_done", 32'(frame_done), 32'd1);
    chk("cont lane1 const", m_re[63:32], 32'hE080_0000);
    run_beats("cont next", 0, NBEATS - 1, RE0, IM0, ZF2);
    chk("cont next frame_done", 32'(frame_done), 32'd1);
    chk("cont next valid", 32'(m_valid), 32'd0);
    zoom_factor = ZF;

    // stop at beat 7 with ready high: abort wins, no frame_done.
    start = 1'b1; tick(); start = 1'b0;
    run_beats("stop", 0, 6, RE0, IM0, ZF);
    check_beat("stop", 7, RE0, IM0, ZF);
    stop = 1'b1; tick(); stop = 1'b0;
    check_idle("stop");
    tick();
    check_idle("stop later");

    // Restart, then reset at beat 9.
    start = 1'b1; tick(); start = 1'b0;
    run_beats("rst", 0, 8, RE0, IM0, ZF);
    check_beat("rst", 9, RE0, IM0, ZF);
    areset = 1'b1; tick(); areset = 1'b0;
    check_idle("rst");
    chk("rst re0 cleared", m_re[31:0], 32'd0);
    tick();
    check_idle("rst later");
    start = 1'b1; tick(); start = 1'b0;
    run_beats("rst again", 0, NBEATS - 1, RE0, IM0, ZF);
    chk("rst again frame_done", 32'(frame_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
